// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - opcode in, datapath control strobes out for the multicycle MIPS controller
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       illegal_op;

    modport master (
        input  opcode,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal_op
    );

    modport slave (
        output opcode,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal_op
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for the MIPS multicycle datapath with memory wait states
module multicycle_control #(
    parameter int MEM_WAIT = 0,
    parameter int WAIT_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BEQ    = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT);

    state_t            state_q, state_n;
    logic [WAIT_W-1:0] wait_q, wait_n;
    ctrl_t             ctrl_q;
    logic              wait_done;
    logic              last_n;
    logic              op_legal;

    // Outputs for the state being entered; `last` marks the final cycle of a held memory state.
    function automatic ctrl_t decode(input state_t s, input logic last);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.ir_write  = last;
                c.pc_write  = last;
            end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                c.i_or_d    = 1'b1;
                c.mem_write = last;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_RWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDIWB: c.reg_write = 1'b1;
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign wait_done = (wait_q == WAIT_LAST);
    assign last_n    = (wait_n == WAIT_LAST);

    always_comb begin
        op_legal = 1'b0;
        case (bus.opcode)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    // Held memory states count up in wait_q; every other transition restarts it at 0.
    always_comb begin
        state_n = S_FETCH;
        wait_n  = '0;
        case (state_q)
            S_IDLE: state_n = S_FETCH;
            S_FETCH: begin
                if (wait_done) begin
                    state_n = S_DECODE;
                end else begin
                    state_n = S_FETCH;
                    wait_n  = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_RTYPE:     state_n = S_EXEC;
                    OP_BEQ:       state_n = S_BEQ;
                    OP_ADDI:      state_n = S_ADDIEX;
                    OP_J:         state_n = S_JUMP;
                    default:      state_n = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.opcode == OP_LW)      state_n = S_MEMRD;
                else if (bus.opcode == OP_SW) state_n = S_MEMWR;
                else                          state_n = S_FETCH;
            end
            S_MEMRD: begin
                if (wait_done) begin
                    state_n = S_MEMWB;
                end else begin
                    state_n = S_MEMRD;
                    wait_n  = wait_q + 1'b1;
                end
            end
            S_MEMWR: begin
                if (wait_done) begin
                    state_n = S_FETCH;
                end else begin
                    state_n = S_MEMWR;
                    wait_n  = wait_q + 1'b1;
                end
            end
            S_EXEC:   state_n = S_RWB;
            S_ADDIEX: state_n = S_ADDIWB;
            default:  state_n = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_n;
            wait_q  <= wait_n;
            ctrl_q  <= decode(state_n, last_n);
        end
    end

    // The IR only becomes valid at the end of FETCH, so the illegal flag is decoded live in DECODE.
    assign bus.illegal_op    = (state_q == S_DECODE) && !op_legal;
    assign bus.state         = state_q;
    assign bus.pc_write      = ctrl_q.pc_write;
    assign bus.pc_write_cond = ctrl_q.pc_write_cond;
    assign bus.i_or_d        = ctrl_q.i_or_d;
    assign bus.mem_read      = ctrl_q.mem_read;
    assign bus.mem_write     = ctrl_q.mem_write;
    assign bus.ir_write      = ctrl_q.ir_write;
    assign bus.reg_dst       = ctrl_q.reg_dst;
    assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
    assign bus.reg_write     = ctrl_q.reg_write;
    assign bus.alu_src_a     = ctrl_q.alu_src_a;
    assign bus.alu_src_b     = ctrl_q.alu_src_b;
    assign bus.alu_op        = ctrl_q.alu_op;
    assign bus.pc_source     = ctrl_q.pc_source;
endmodule
